// File: rtl/ntt_cmd_pkg.sv
// ---------------------------------------------------------------------------
// ntt_cmd_pkg
// Shared definitions for the custom-0 buffer/NTT command responder:
//   - CUSTOM0 opcode / funct3 that route an instruction to this unit
//   - funct7 command codes
//   - NTT engine mode encodings
//   - command FSM state enum
//   - small decode helpers used by the top-level FSM
// ---------------------------------------------------------------------------
package ntt_cmd_pkg;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_NTT_CMD  = 3'b011;

    localparam logic [6:0] F7_LBUF   = 7'd0;
    localparam logic [6:0] F7_SBUF   = 7'd1;
    localparam logic [6:0] F7_NTT    = 7'd3;
    localparam logic [6:0] F7_INVNTT = 7'd4;
    localparam logic [6:0] F7_LPWAM  = 7'd5;
    localparam logic [6:0] F7_PWAM   = 7'd7;

    typedef enum logic [1:0] {
        MODE_NTT    = 2'b00,
        MODE_INVNTT = 2'b01,
        MODE_PWAM   = 2'b10,
        MODE_LPWAM  = 2'b11
    } eng_mode_e;

    typedef enum logic [3:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_RD,
        ST_REQ,
        ENG_START,
        ENG_WAIT,
        ERR,
        DONE
    } state_e;

    function automatic logic f7_is_legal(input logic [6:0] f7);
        return (f7 == F7_LBUF)   || (f7 == F7_SBUF)  || (f7 == F7_NTT) ||
               (f7 == F7_INVNTT) || (f7 == F7_LPWAM) || (f7 == F7_PWAM);
    endfunction

    // Buffer transfers are the only commands that touch memory and therefore
    // the only ones that need a word-aligned base address.
    function automatic logic f7_is_xfer(input logic [6:0] f7);
        return (f7 == F7_LBUF) || (f7 == F7_SBUF);
    endfunction

    function automatic eng_mode_e f7_to_mode(input logic [6:0] f7);
        eng_mode_e m;
        case (f7)
            F7_INVNTT: m = MODE_INVNTT;
            F7_PWAM:   m = MODE_PWAM;
            F7_LPWAM:  m = MODE_LPWAM;
            default:   m = MODE_NTT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ntt_xfer_ctr.sv
// ---------------------------------------------------------------------------
// ntt_xfer_ctr
// Word counter and address generator for buffer <-> memory transfers.
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       latch base_i and restart the count at word 0
//   base_i       transfer base address (rs1)
//   inc_i        advance to the next word
//   idx_o        current word index (also the buffer word address)
//   last_o       current word is word N_WORDS-1
//   addr_o       memory address of the current word: base + 8*idx (wraps)
// ---------------------------------------------------------------------------
module ntt_xfer_ctr #(
    parameter int N_WORDS = 64,
    parameter int BUF_AW  = 6,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              inc_i,
    output logic [BUF_AW-1:0] idx_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] base_q;
    logic [BUF_AW-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            base_q <= base_i;
            idx_q  <= '0;
        end else if (inc_i) begin
            idx_q  <= idx_q + 1'b1;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == BUF_AW'(N_WORDS - 1));
    // Modulo-2^ADDR_W sum: a transfer crossing the top of memory simply wraps.
    assign addr_o = base_q + (ADDR_W'(idx_q) << 3);

endmodule

// File: rtl/ntt_cmd_unit.sv
// ---------------------------------------------------------------------------
// ntt_cmd_unit
// Executes custom-0 buffer/NTT commands accepted from the execute stage.
//   cmd_valid/cmd_ready/cmd_funct7/cmd_addr   command handshake + operands
//   busy, done, err                           pipeline stall, completion and
//                                             error pulses
//   mem_*                                     data-memory request port
//                                             (req/gnt, rvalid for loads)
//   buf_*                                     local coefficient buffer port
//                                             (read data has 1-cycle latency)
//   eng_start/eng_mode/ntt_md/eng_done        NTT engine control
// LBUF copies N_WORDS words memory->buffer, SBUF buffer->memory; compute
// commands pulse eng_start and wait for eng_done.
// ---------------------------------------------------------------------------
module ntt_cmd_unit
    import ntt_cmd_pkg::*;
#(
    parameter int N_WORDS = 64,
    parameter int BUF_AW  = 6,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [6:0]        cmd_funct7,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              buf_we,
    output logic [BUF_AW-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic              eng_start,
    output logic [1:0]        eng_mode,
    output logic              ntt_md,
    input  logic              eng_done
);

    state_e            state_q, state_d;
    eng_mode_e         eng_mode_q;
    logic              ntt_md_q;
    logic              st_first_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              cmd_bad;
    logic              ctr_inc;
    logic [BUF_AW-1:0] idx;
    logic              last;
    logic [ADDR_W-1:0] word_addr;

    assign accept  = cmd_valid && (state_q == IDLE);
    assign cmd_bad = !f7_is_legal(cmd_funct7) ||
                     (f7_is_xfer(cmd_funct7) && (cmd_addr[2:0] != 3'b000));
    assign ctr_inc = !last && (((state_q == LD_WAIT) && mem_rvalid) ||
                               ((state_q == ST_REQ)  && mem_gnt));

    ntt_xfer_ctr #(
        .N_WORDS (N_WORDS),
        .BUF_AW  (BUF_AW),
        .ADDR_W  (ADDR_W)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .base_i (cmd_addr),
        .inc_i  (ctr_inc),
        .idx_o  (idx),
        .last_o (last),
        .addr_o (word_addr)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad)                      state_d = ERR;
                    else if (cmd_funct7 == F7_LBUF)   state_d = LD_REQ;
                    else if (cmd_funct7 == F7_SBUF)   state_d = ST_RD;
                    else                              state_d = ENG_START;
                end
            end
            LD_REQ:    if (mem_gnt)    state_d = LD_WAIT;
            LD_WAIT:   if (mem_rvalid) state_d = last ? DONE : LD_REQ;
            ST_RD:                     state_d = ST_REQ;
            ST_REQ:    if (mem_gnt)    state_d = last ? DONE : ST_RD;
            ENG_START:                 state_d = ENG_WAIT;
            ENG_WAIT:  if (eng_done)   state_d = DONE;
            ERR:                       state_d = IDLE;
            DONE:                      state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        buf_we    = 1'b0;
        buf_addr  = '0;
        buf_wdata = '0;
        eng_start = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            LD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = word_addr;
            end
            LD_WAIT: begin
                buf_addr = idx;
                if (mem_rvalid) begin
                    buf_we    = 1'b1;
                    buf_wdata = mem_rdata;
                end
            end
            ST_RD: begin
                buf_addr = idx;
            end
            ST_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                // The buffer's read data is valid only in the first ST_REQ
                // cycle; later gnt wait-states replay the captured copy.
                mem_wdata = st_first_q ? buf_rdata : wdata_q;
            end
            ENG_START: eng_start = 1'b1;
            ERR:       err       = 1'b1;
            DONE:      done      = 1'b1;
            default: ;
        endcase
    end

    assign eng_mode = eng_mode_q;
    assign ntt_md   = ntt_md_q;

    // Engine mode/direction are latched only for compute commands so they stay
    // put for the whole time the engine is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_mode_q <= MODE_NTT;
            ntt_md_q   <= 1'b1;
        end else if (accept && !cmd_bad && !f7_is_xfer(cmd_funct7)) begin
            eng_mode_q <= f7_to_mode(cmd_funct7);
            ntt_md_q   <= (cmd_funct7 != F7_INVNTT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_first_q <= 1'b0;
        end else begin
            st_first_q <= (state_q == ST_RD);
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == ST_REQ) && st_first_q) begin
            wdata_q <= buf_rdata;
        end
    end

endmodule

// File: tb/tb_ntt_cmd_unit.sv
module tb_ntt_cmd_unit;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_funct7;
    logic [63:0] cmd_addr;
    logic        busy, done, err;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;
    logic        buf_we;
    logic [5:0]  buf_addr;
    logic [63:0] buf_wdata, buf_rdata;
    logic        eng_start;
    logic [1:0]  eng_mode;
    logic        ntt_md;
    logic        eng_done;

    always #5 clk = ~clk;

    ntt_cmd_unit #(.N_WORDS(NW), .BUF_AW(6), .ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_funct7(cmd_funct7), .cmd_addr(cmd_addr),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .buf_rdata(buf_rdata),
        .eng_start(eng_start), .eng_mode(eng_mode), .ntt_md(ntt_md),
        .eng_done(eng_done)
    );

    int total = 0;
    int bad   = 0;

    // bench-side memory / buffer model state
    logic [63:0] bufm [0:63];
    logic        ld_pend;
    logic [63:0] ld_addr;
    logic [63:0] stall_addr;
    int          stall_left;

    // per-cycle samples
    logic        s_ready, s_busy, s_done, s_err, s_req, s_we, s_gnt;
    logic        s_buf_we, s_start;
    logic [63:0] s_addr, s_wdata, s_buf_wdata;
    logic [5:0]  s_buf_addr;
    logic [1:0]  s_mode;
    logic        s_md;

    // per-run logs
    int          cyc_n;
    int          done_cnt, err_cnt, start_cnt, bufwe_cnt, req_cnt;
    logic [63:0] ld_log[$];
    logic [63:0] st_addr_log[$];
    logic [63:0] st_data_log[$];

    task automatic clear_logs();
        cyc_n = 0; done_cnt = 0; err_cnt = 0; start_cnt = 0;
        bufwe_cnt = 0; req_cnt = 0;
        ld_log.delete(); st_addr_log.delete(); st_data_log.delete();
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic cyc();
        mem_rvalid = ld_pend;
        mem_rdata  = ld_pend ? ld_addr : 64'h0;
        ld_pend    = 1'b0;
        #1;
        if (mem_req && stall_left > 0 && mem_addr == stall_addr) begin
            mem_gnt = 1'b0;
            stall_left--;
        end else begin
            mem_gnt = mem_req;
        end
        #1;
        s_ready = cmd_ready; s_busy = busy; s_done = done; s_err = err;
        s_req = mem_req; s_we = mem_we; s_gnt = mem_gnt;
        s_addr = mem_addr; s_wdata = mem_wdata;
        s_buf_we = buf_we; s_buf_addr = buf_addr; s_buf_wdata = buf_wdata;
        s_start = eng_start; s_mode = eng_mode; s_md = ntt_md;
        if (s_done)   done_cnt++;
        if (s_err)    err_cnt++;
        if (s_start)  start_cnt++;
        if (s_buf_we) bufwe_cnt++;
        if (s_req)    req_cnt++;
        @(posedge clk);
        #1;
        if (s_buf_we) bufm[s_buf_addr] = s_buf_wdata;
        buf_rdata = bufm[s_buf_addr];
        if (s_req && s_gnt) begin
            if (s_we) begin
                st_addr_log.push_back(s_addr);
                st_data_log.push_back(s_wdata);
            end else begin
                ld_pend = 1'b1;
                ld_addr = s_addr;
                ld_log.push_back(s_addr);
            end
        end
        cyc_n++;
    endtask

    // Present a command for one cycle (cycle 0 of the run).
    task automatic issue(input logic [6:0] f7, input logic [63:0] addr);
        clear_logs();
        cmd_valid = 1'b1; cmd_funct7 = f7; cmd_addr = addr;
        cyc();
        cmd_valid = 1'b0; cmd_funct7 = 7'd0; cmd_addr = 64'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        total++; if (ntt_md !== 1'b1) begin bad++; $display("FAIL reset_ntt_md: got %b want 1", ntt_md); end
        total++; if ({busy, done, err, mem_req, mem_we, buf_we, eng_start} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl_outs: got %b want 0000000", {busy, done, err, mem_req, mem_we, buf_we, eng_start}); end
        total++; if ({mem_addr, mem_wdata, buf_wdata} !== 192'h0 || buf_addr !== 6'd0 || eng_mode !== 2'b00) begin
            bad++; $display("FAIL reset_data_outs: got addr=%h wdata=%h mode=%b want 0", mem_addr, mem_wdata, eng_mode); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lbuf();
        int done_at = -1;
        int busy_bad = 0;
        for (int k = 0; k < NW; k++) bufm[k] = 64'h0;
        issue(7'd0, 64'h1000);
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (s_done && done_at < 0) done_at = c;
            if (s_busy !== (c <= 9)) busy_bad++;
        end
        total++; if (done_at !== 9) begin bad++; $display("FAIL lbuf_done_cycle: got %0d want 9", done_at); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL lbuf_done_count: got %0d want 1", done_cnt); end
        total++; if (busy_bad !== 0) begin bad++; $display("FAIL lbuf_busy_window: got %0d wrong cycles want 0", busy_bad); end
        for (int k = 0; k < NW; k++) begin
            total++;
            if (bufm[k] !== 64'h1000 + 64'(8 * k)) begin
                bad++; $display("FAIL lbuf_word%0d: got %h want %h", k, bufm[k], 64'h1000 + 64'(8 * k));
            end
        end
        total++; if (st_addr_log.size() !== 0 || ld_log.size() !== NW) begin
            bad++; $display("FAIL lbuf_mem_ops: got loads=%0d stores=%0d want 4/0", ld_log.size(), st_addr_log.size()); end
    endtask

    task automatic test_sbuf();
        int done_at = -1;
        int waits = 0;
        for (int k = 0; k < NW; k++) bufm[k] = 64'hA0 + 64'(k);
        stall_addr = 64'h2010;
        stall_left = 3;
        issue(7'd1, 64'h2000);
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (s_done && done_at < 0) done_at = c;
            if (s_req && !s_gnt) begin
                waits++;
                total++;
                if (s_addr !== 64'h2010 || s_wdata !== 64'hA2) begin
                    bad++; $display("FAIL sbuf_wait_stable: got addr=%h data=%h want 2010/a2", s_addr, s_wdata);
                end
            end
        end
        total++; if (waits !== 3) begin bad++; $display("FAIL sbuf_wait_cycles: got %0d want 3", waits); end
        total++; if (done_at !== 12) begin bad++; $display("FAIL sbuf_done_cycle: got %0d want 12", done_at); end
        total++; if (st_addr_log.size() !== NW) begin bad++; $display("FAIL sbuf_store_count: got %0d want 4", st_addr_log.size()); end
        for (int k = 0; k < NW && k < st_addr_log.size(); k++) begin
            total++;
            if (st_addr_log[k] !== 64'h2000 + 64'(8 * k) || st_data_log[k] !== 64'hA0 + 64'(k)) begin
                bad++; $display("FAIL sbuf_store%0d: got %h/%h want %h/%h", k, st_addr_log[k], st_data_log[k],
                                64'h2000 + 64'(8 * k), 64'hA0 + 64'(k));
            end
        end
    endtask

    task automatic test_invntt();
        int start_at = -1;
        int done_at  = -1;
        logic [1:0] mode_mid = 2'bxx;
        logic       md_mid   = 1'bx;
        clear_logs();
        eng_done = 1'b1;
        repeat (2) cyc();
        eng_done = 1'b0;
        total++; if (done_cnt !== 0 || start_cnt !== 0 || s_busy !== 1'b0) begin
            bad++; $display("FAIL spurious_eng_done: got done=%0d start=%0d busy=%b want 0/0/0", done_cnt, start_cnt, s_busy); end
        issue(7'd4, 64'h5);
        for (int c = 1; c <= 16; c++) begin
            eng_done = (c == 1 || c == 11);
            cyc();
            if (s_start && start_at < 0) start_at = c;
            if (s_done && done_at < 0) done_at = c;
            if (c == 5) begin mode_mid = s_mode; md_mid = s_md; end
        end
        eng_done = 1'b0;
        total++; if (start_cnt !== 1 || start_at !== 1) begin
            bad++; $display("FAIL inv_start_pulse: got count=%0d at=%0d want 1 at 1", start_cnt, start_at); end
        total++; if (done_at !== 12 || done_cnt !== 1) begin
            bad++; $display("FAIL inv_done: got at=%0d count=%0d want 12/1", done_at, done_cnt); end
        total++; if (mode_mid !== 2'b01) begin bad++; $display("FAIL inv_eng_mode: got %b want 01", mode_mid); end
        total++; if (md_mid !== 1'b0) begin bad++; $display("FAIL inv_ntt_md: got %b want 0", md_mid); end
        total++; if (req_cnt !== 0) begin bad++; $display("FAIL inv_no_mem: got %0d req cycles want 0", req_cnt); end
    endtask

    task automatic test_err();
        logic [63:0] addrs [2];
        logic [6:0]  f7s   [2];
        int err_at;
        logic rdy1, rdy2, busy1;
        addrs[0] = 64'h1000; f7s[0] = 7'd2;
        addrs[1] = 64'h1004; f7s[1] = 7'd0;
        for (int t = 0; t < 2; t++) begin
            err_at = -1; rdy1 = 1'bx; rdy2 = 1'bx; busy1 = 1'bx;
            issue(f7s[t], addrs[t]);
            for (int c = 1; c <= 4; c++) begin
                cyc();
                if (s_err && err_at < 0) err_at = c;
                if (c == 1) begin rdy1 = s_ready; busy1 = s_busy; end
                if (c == 2) rdy2 = s_ready;
            end
            total++; if (err_cnt !== 1 || err_at !== 1) begin
                bad++; $display("FAIL err%0d_pulse: got count=%0d at=%0d want 1 at 1", t, err_cnt, err_at); end
            total++; if (busy1 !== 1'b1 || rdy1 !== 1'b0 || rdy2 !== 1'b1) begin
                bad++; $display("FAIL err%0d_handshake: got busy1=%b rdy1=%b rdy2=%b want 1/0/1", t, busy1, rdy1, rdy2); end
            total++; if (req_cnt !== 0 || bufwe_cnt !== 0 || done_cnt !== 0 || start_cnt !== 0) begin
                bad++; $display("FAIL err%0d_quiet: got req=%0d bufwe=%0d done=%0d start=%0d want 0", t,
                                req_cnt, bufwe_cnt, done_cnt, start_cnt); end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_a [4];
        exp_a[0] = 64'hFFFF_FFFF_FFFF_FFF8; exp_a[1] = 64'h0;
        exp_a[2] = 64'h8;                   exp_a[3] = 64'h10;
        issue(7'd0, 64'hFFFF_FFFF_FFFF_FFF8);
        for (int c = 1; c <= 12; c++) cyc();
        total++; if (ld_log.size() !== 4 || done_cnt !== 1 || err_cnt !== 0) begin
            bad++; $display("FAIL wrap_counts: got loads=%0d done=%0d err=%0d want 4/1/0", ld_log.size(), done_cnt, err_cnt); end
        for (int k = 0; k < 4 && k < ld_log.size(); k++) begin
            total++;
            if (ld_log[k] !== exp_a[k]) begin
                bad++; $display("FAIL wrap_addr%0d: got %h want %h", k, ld_log[k], exp_a[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        int done_at = -1;
        issue(7'd0, 64'h3000);
        for (int c = 1; c <= 5; c++) cyc();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy: got %b want 1", busy); end
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD;
        mem_gnt    = 1'b0;
        rst_n      = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || ntt_md !== 1'b1) begin
            bad++; $display("FAIL arst_immediate: got ready=%b busy=%b md=%b want 1/0/1", cmd_ready, busy, ntt_md); end
        total++; if (buf_we !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || buf_addr !== 6'd0) begin
            bad++; $display("FAIL arst_quiet: got bufwe=%b req=%b done=%b baddr=%0d want 0", buf_we, mem_req, done, buf_addr); end
        mem_rvalid = 1'b0;
        ld_pend    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        repeat (3) cyc();
        total++; if (done_cnt !== 0 || s_busy !== 1'b0) begin
            bad++; $display("FAIL arst_no_done: got done=%0d busy=%b want 0/0", done_cnt, s_busy); end
        for (int k = 0; k < NW; k++) bufm[k] = 64'h0;
        issue(7'd0, 64'h4000);
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (s_done && done_at < 0) done_at = c;
        end
        total++; if (ld_log.size() < 1 || ld_log[0] !== 64'h4000) begin
            bad++; $display("FAIL arst_restart_addr: got %h want 4000", (ld_log.size() > 0) ? ld_log[0] : 64'hx); end
        total++; if (bufm[0] !== 64'h4000 || bufm[3] !== 64'h4018 || done_at !== 9) begin
            bad++; $display("FAIL arst_restart_data: got w0=%h w3=%h done=%0d want 4000/4018/9", bufm[0], bufm[3], done_at); end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_funct7 = 7'd0; cmd_addr = 64'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
        buf_rdata = 64'h0; eng_done = 1'b0;
        ld_pend = 1'b0; ld_addr = 64'h0; stall_addr = 64'h0; stall_left = 0;
        for (int k = 0; k < 64; k++) bufm[k] = 64'h0;
        clear_logs();
        test_reset();
        test_lbuf();
        test_sbuf();
        test_invntt();
        test_err();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_cmd_unit.md
Name: ntt_cmd_unit

Overview:
- Responder for the custom-0 buffer/NTT instructions (opcode 0001011, funct3 011) that the instruction decoder issues.
- Takes an accepted command (funct7 plus the rs1 base address) and executes it:
  - LBUF: copies N_WORDS 64-bit words from data memory into the local coefficient buffer.
  - SBUF: copies the buffer back to data memory.
  - NTT, INVNTT, PWAM, LPWAM: start the NTT engine and wait for it to finish.
- Sits between the execute stage, the data-memory port and the NTT engine. Holds the pipeline via `busy`.

Parameters:
- N_WORDS, 64: words per transfer (256 × 16-bit coefficients).
- BUF_AW, 6: buffer address width; must satisfy 2^BUF_AW ≥ N_WORDS.
- ADDR_W, 64: memory address width.
- DATA_W, 64: memory and buffer word width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit can accept a command; high only in IDLE.
- cmd_funct7  in  7  command code.
- cmd_addr  in  ADDR_W  rs1 base address.
- busy  out  1  command in progress (pipeline stall).
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on an illegal funct7 or a misaligned address.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  DATA_W  load data.
- buf_we  out  1  buffer write enable.
- buf_addr  out  BUF_AW  buffer word address.
- buf_wdata  out  DATA_W  buffer write data.
- buf_rdata  in  DATA_W  buffer read data, one-cycle latency.
- eng_start  out  1  one-cycle engine start pulse.
- eng_mode  out  2  00 NTT, 01 INVNTT, 10 PWAM, 11 LPWAM; held stable while busy.
- ntt_md  out  1  1 = forward, 0 = inverse; held stable while busy.
- eng_done  in  1  engine finished.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State goes to IDLE.
  - All outputs are 0 except cmd_ready = 1 and ntt_md = 1.
  - The word counter clears.
  - An in-flight memory or engine operation is abandoned; no done or err pulse is produced.
- Accept: a command is taken when cmd_valid && cmd_ready at a clock edge. funct7 and the address are latched at that edge. busy = 1 from the next cycle until DONE is left.
- Legal funct7 codes: 0 LBUF, 1 SBUF, 3 NTT, 4 INVNTT, 7 PWAM, 5 LPWAM.
- Error path:
  - Any other funct7, or an LBUF/SBUF with cmd_addr[2:0] ≠ 0, goes to ERR.
  - ERR lasts one cycle with err = 1 and busy = 1, then returns to IDLE.
  - No memory, buffer or engine activity occurs.
- Word address: base + 8·i, computed modulo 2^ADDR_W (wrap permitted, not flagged). The counter i runs 0..N_WORDS-1.
- LBUF sequence:
  - LD_REQ: mem_req = 1, mem_we = 0. Stay until mem_gnt, then go to LD_WAIT.
  - LD_WAIT: wait for mem_rvalid. In that cycle buf_we = 1, buf_addr = i, buf_wdata = mem_rdata.
  - If i = N_WORDS-1 go to DONE; otherwise increment i and return to LD_REQ.
  - At most one outstanding load.
- SBUF sequence:
  - ST_RD: buf_addr = i, one cycle.
  - ST_REQ: mem_req = 1, mem_we = 1, mem_wdata = buf_rdata. buf_rdata is registered on ST_RD exit so it stays stable across gnt wait-states.
  - On mem_gnt: go to DONE if i is last; otherwise increment i and go to ST_RD.
- Compute sequence:
  - ENG_START: eng_start = 1 for one cycle, then go to ENG_WAIT.
  - ENG_WAIT: stay until eng_done, then go to DONE.
  - eng_done is sampled only in ENG_WAIT; a done asserted during ENG_START or IDLE is ignored.
- DONE: lasts one cycle with done = 1, then IDLE.
- Throughput: cmd_ready is 0 in ERR and DONE, so consecutive commands are at least two cycles apart after completion.
- Zero-wait memory (gnt same cycle, rvalid next cycle): LBUF done pulse falls in cycle 2·N_WORDS+1 after accept; SBUF likewise.
- mem_req is held with stable address and data until mem_gnt; it is never dropped early.

Decomposition:
- Shared package ntt_cmd_pkg holds:
  - funct7 codes: F7_LBUF = 0, F7_SBUF = 1, F7_NTT = 3, F7_INVNTT = 4, F7_LPWAM = 5, F7_PWAM = 7.
  - eng_mode encodings.
  - FSM state enum: IDLE, LD_REQ, LD_WAIT, ST_RD, ST_REQ, ENG_START, ENG_WAIT, ERR, DONE.
  - CUSTOM0 opcode and funct3 constants.
- One sub-module is natural: ntt_xfer_ctr, holding the word counter, last-word flag and address generator (base + 8·i).

Test Plan:
- N_WORDS = 4, zero-wait memory, LBUF at base 0x1000 returning rdata = addr → buf words 0..3 = 0x1000, 0x1008, 0x1010, 0x1018; done in cycle 9 after accept; busy high in cycles 1–9.
- SBUF at 0x2000 with buffer preloaded to i+0xA0, mem_gnt delayed 3 cycles on word 2 → stores (0x2000, 0xA0) … (0x2018, 0xA3) in order; mem_addr and mem_wdata stable during the wait.
- INVNTT (funct7 = 4), eng_done 10 cycles after start, plus a spurious eng_done during IDLE → eng_mode = 01, ntt_md = 0, a single eng_start pulse, done one cycle after eng_done; the spurious done is ignored.
- funct7 = 2, and separately LBUF at 0x1004 → err pulse for one cycle, no mem_req, no buf_we, no done; cmd_ready back to 1 two cycles after accept.
- LBUF at 0xFFFF_FFFF_FFFF_FFF8 with N_WORDS = 4 → addresses wrap to 0xFFFF_FFFF_FFFF_FFF8, 0x0, 0x8, 0x10.
- rst_n low while in LD_WAIT on word 2, then released → all outputs at reset values immediately (asynchronous); no done pulse; a new LBUF accepted afterwards starts at word 0.
